// File: rtl/counter.sv
// Free-running up-counter with terminal-count decode, wrapping after MAX_VAL.
// Define COUNTER_SATURATE_EN to hold at MAX_VAL instead of wrapping.
module counter #(
    parameter int              WIDTH   = 4,
    parameter longint unsigned MAX_VAL = (64'd1 << WIDTH) - 64'd1
) (
    input  logic             clk,
    input  logic             rst,
    output logic [WIDTH-1:0] count,
    output logic             tc
);

    localparam longint unsigned LIMIT = (64'd1 << WIDTH) - 64'd1;

    if (WIDTH < 1 || WIDTH > 32 || MAX_VAL == 64'd0 || MAX_VAL > LIMIT) begin : g_param_check
        $fatal(1, "counter: illegal WIDTH/MAX_VAL combination");
    end

    localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_VAL);

    logic at_max;
    logic over_max;

    assign at_max   = (count == MAX_W);
    assign over_max = (count > MAX_W);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (over_max) begin
            // Only reachable from an unknown or upset state.
            count <= '0;
        end else if (at_max) begin
`ifdef COUNTER_SATURATE_EN
            count <= MAX_W;
`else
            count <= '0;
`endif
        end else begin
            count <= count + WIDTH'(1);
        end
    end

    assign tc = at_max;

endmodule

// File: tb/tb_counter.sv
// Self-checking bench for counter: default modulus-16 and modulus-10 instances
// against an arithmetic reference model, plus hand-computed literal checkpoints.
module tb_counter;

    logic       clk;
    logic       rst;
    logic [3:0] count16;
    logic       tc16;
    logic [3:0] count10;
    logic       tc10;

    int n_checks = 0;
    int n_pass   = 0;

    counter dut16 (
        .clk   (clk),
        .rst   (rst),
        .count (count16),
        .tc    (tc16)
    );

    counter #(.WIDTH(4), .MAX_VAL(9)) dut10 (
        .clk   (clk),
        .rst   (rst),
        .count (count10),
        .tc    (tc10)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at t=%0t: got %0d, expected %0d", nm, $time, act, exp);
    endtask

    // Reference model: next value from the counting rule, in plain integers.
    function automatic int next_val(input int v, input int mx);
`ifdef COUNTER_SATURATE_EN
        return (v >= mx) ? mx : v + 1;
`else
        return (v >= mx) ? 0 : v + 1;
`endif
    endfunction

    bit m_valid = 1'b0;
    int m16 = 0;
    int m10 = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_valid = 1'b1;
            m16 = 0;
            m10 = 0;
        end else if (m_valid) begin
            m16 = next_val(m16, 15);
            m10 = next_val(m10, 9);
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("model_count16", 32'(count16), 32'(m16));
            chk("model_tc16",    32'(tc16),    32'(m16 == 15));
            chk("model_count10", 32'(count10), 32'(m10));
            chk("model_tc10",    32'(tc10),    32'(m10 == 9));
        end
    end

    initial begin
        rst = 1'b0;
        #13 rst = 1'b1;                  // t=13
        #7  chk("reset_count16", 32'(count16), 0);   // t=20
            chk("reset_tc16",    32'(tc16), 0);
            chk("reset_count10", 32'(count10), 0);
        #2  rst = 1'b0;                  // t=22
        #38 chk("release_count16_4", 32'(count16), 4); // t=60
        #2  rst = 1'b1;                  // t=62
        #8  chk("midreset_count16", 32'(count16), 0);  // t=70
        #1  rst = 1'b0;                  // t=71
        #89 chk("mod10_top_count", 32'(count10), 9);   // t=160
            chk("mod10_top_tc",    32'(tc10), 1);
        #11 chk("after10_count16", 32'(count16), 10);  // t=171
`ifdef COUNTER_SATURATE_EN
            chk("after10_count10", 32'(count10), 9);
            chk("after10_tc10",    32'(tc10), 1);
`else
            chk("after10_count10", 32'(count10), 0);
            chk("after10_tc10",    32'(tc10), 0);
`endif
        #49 chk("wrap_top_count16", 32'(count16), 15); // t=220
            chk("wrap_top_tc16",    32'(tc16), 1);
        #10                                           // t=230
`ifdef COUNTER_SATURATE_EN
            chk("wrap_next_count16", 32'(count16), 15);
            chk("wrap_next_tc16",    32'(tc16), 1);
`else
            chk("wrap_next_count16", 32'(count16), 0);
            chk("wrap_next_tc16",    32'(tc16), 0);
`endif
        #1  rst = 1'b1;                  // t=231, glitch between edges
        #3  rst = 1'b0;                  // t=234
        #6                                            // t=240
`ifdef COUNTER_SATURATE_EN
            chk("glitch_count16", 32'(count16), 15);
`else
            chk("glitch_count16", 32'(count16), 1);
`endif
        #2  rst = 1'b1;                  // t=242, held over edges 245..285
        #48 chk("held_count16", 32'(count16), 0);      // t=290
            chk("held_tc16",    32'(tc16), 0);
            chk("held_count10", 32'(count10), 0);
        #1  rst = 1'b0;                  // t=291, then 20 edges 295..485
        #199                                          // t=490
`ifdef COUNTER_SATURATE_EN
            chk("run20_count16", 32'(count16), 15);
            chk("run20_tc16",    32'(tc16), 1);
            chk("run20_count10", 32'(count10), 9);
`else
            chk("run20_count16", 32'(count16), 4);
            chk("run20_tc16",    32'(tc16), 0);
            chk("run20_count10", 32'(count10), 0);
`endif
        #2  rst = 1'b1;                  // t=492
        #5  rst = 1'b0;                  // t=497
        #3  chk("final_reset_count16", 32'(count16), 0); // t=500
            chk("final_reset_tc16",    32'(tc16), 0);
        #20 chk("final_run_count16", 32'(count16), 2);   // t=520
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
